// File: rtl/vga_port_arbiter.sv
// Round-robin arbiter that gives the drawing engines exclusive bursts on the VGA plot port.
// A hold-time watchdog revokes a stuck owner, which must then drop its request before it can be granted again.
module vga_port_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 100000,
  parameter int HOLD_W   = 17
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     plot_in,
  input  logic [9*NUM_REQ-1:0]   x_in,
  input  logic [8*NUM_REQ-1:0]   y_in,
  input  logic [3*NUM_REQ-1:0]   color_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [8:0]             vga_x,
  output logic [7:0]             vga_y,
  output logic [2:0]             vga_color,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   timeout_pulse,
  output logic [1:0]             timeout_id
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_ptr_q, last_ptr_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]   mask_q, mask_d;
  logic [8:0]           vga_x_q, vga_x_d;
  logic [7:0]           vga_y_q, vga_y_d;
  logic [2:0]           vga_color_q, vga_color_d;
  logic                 vga_plot_q, vga_plot_d;
  logic                 timeout_pulse_q, timeout_pulse_d;
  logic [1:0]           timeout_id_q, timeout_id_d;

  logic [8:0]           x_arr     [NUM_REQ];
  logic [7:0]           y_arr     [NUM_REQ];
  logic [2:0]           color_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign x_arr[gi]     = x_in[9*gi +: 9];
    assign y_arr[gi]     = y_in[8*gi +: 8];
    assign color_arr[gi] = color_in[3*gi +: 3];
  end

  assign eligible = req & ~mask_q;

  // Rotating scan starting just after the last winner; the first eligible index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_ptr_q) + k) % NUM_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    owner_d         = owner_q;
    last_ptr_d      = last_ptr_q;
    hold_cnt_d      = hold_cnt_q;
    mask_d          = mask_q & req;
    vga_x_d         = vga_x_q;
    vga_y_d         = vga_y_q;
    vga_color_d     = vga_color_q;
    vga_plot_d      = 1'b0;
    timeout_pulse_d = 1'b0;
    timeout_id_d    = timeout_id_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          last_ptr_d       = win_idx;
          hold_cnt_d       = '0;
          state_d          = GRANT;
        end
      end
      GRANT: begin
        vga_x_d     = x_arr[owner_q];
        vga_y_d     = y_arr[owner_q];
        vga_color_d = color_arr[owner_q];
        hold_cnt_d  = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
        // Release is checked first so a simultaneous release never counts as a timeout.
        if (!req[owner_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          grant_d          = '0;
          state_d          = IDLE;
          timeout_pulse_d  = 1'b1;
          timeout_id_d     = 2'(owner_q);
          mask_d[owner_q]  = 1'b1;
        end else begin
          vga_plot_d = plot_in[owner_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      owner_q         <= '0;
      last_ptr_q      <= IDX_W'(NUM_REQ - 1);
      hold_cnt_q      <= '0;
      mask_q          <= '0;
      vga_x_q         <= '0;
      vga_y_q         <= '0;
      vga_color_q     <= '0;
      vga_plot_q      <= 1'b0;
      timeout_pulse_q <= 1'b0;
      timeout_id_q    <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      owner_q         <= owner_d;
      last_ptr_q      <= last_ptr_d;
      hold_cnt_q      <= hold_cnt_d;
      mask_q          <= mask_d;
      vga_x_q         <= vga_x_d;
      vga_y_q         <= vga_y_d;
      vga_color_q     <= vga_color_d;
      vga_plot_q      <= vga_plot_d;
      timeout_pulse_q <= timeout_pulse_d;
      timeout_id_q    <= timeout_id_d;
    end
  end

  assign grant         = grant_q;
  assign vga_x         = vga_x_q;
  assign vga_y         = vga_y_q;
  assign vga_color     = vga_color_q;
  assign vga_plot      = vga_plot_q;
  assign busy          = (state_q == GRANT);
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_id    = timeout_id_q;

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Bench for vga_port_arbiter: directed scenarios plus a randomized run against a burst-level reference model.
module tb_vga_port_arbiter;
  localparam int N  = 3;
  localparam int MH = 8;
  localparam int HW = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req, plot_in;
  logic [9*N-1:0]   x_in;
  logic [8*N-1:0]   y_in;
  logic [3*N-1:0]   color_in;
  logic [N-1:0]     grant;
  logic [8:0]       vga_x;
  logic [7:0]       vga_y;
  logic [2:0]       vga_color;
  logic             vga_plot, busy, timeout_pulse;
  logic [1:0]       timeout_id;

  vga_port_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH), .HOLD_W(HW)) dut (
    .clock(clock), .reset(reset), .req(req), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(grant),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
    .busy(busy), .timeout_pulse(timeout_pulse), .timeout_id(timeout_id)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the port, how many granted cycles it has used, and who is locked out.
  int           m_owner;
  int           m_last;
  int           m_used;
  logic [N-1:0] m_locked;
  logic [N-1:0] e_grant;
  logic [8:0]   e_x;
  logic [7:0]   e_y;
  logic [2:0]   e_c;
  logic         e_plot, e_tp, e_busy;
  logic [1:0]   e_tid;

  function automatic void model_edge();
    logic [N-1:0] avail;
    int w;
    bit found;
    if (reset) begin
      m_owner = -1; m_last = N - 1; m_used = 0; m_locked = '0;
      e_grant = '0; e_x = '0; e_y = '0; e_c = '0;
      e_plot = 1'b0; e_tp = 1'b0; e_tid = '0; e_busy = 1'b0;
      return;
    end
    avail    = req & ~m_locked;
    m_locked = m_locked & req;
    e_tp     = 1'b0;
    e_plot   = 1'b0;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        w = (m_last + k) % N;
        if (!found && avail[w]) begin
          found = 1; m_owner = w; m_last = w; m_used = 1;
          e_grant = '0; e_grant[w] = 1'b1;
        end
      end
    end else begin
      e_x = x_in[9*m_owner +: 9];
      e_y = y_in[8*m_owner +: 8];
      e_c = color_in[3*m_owner +: 3];
      if (!req[m_owner]) begin
        m_owner = -1; e_grant = '0;
      end else if (m_used == MH) begin
        e_tp = 1'b1; e_tid = 2'(m_owner); m_locked[m_owner] = 1'b1;
        m_owner = -1; e_grant = '0;
      end else begin
        e_plot = plot_in[m_owner];
        m_used = m_used + 1;
      end
    end
    e_busy = (m_owner >= 0);
  endfunction

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 3'($urandom); plot_in = 3'($urandom);
    x_in = 27'($urandom); y_in = 24'($urandom); color_in = 9'($urandom);
    step(); step();
    vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL reset_grant got %b want 000", grant); end
    vectors++; if (vga_plot !== 1'b0) begin miscompares++; $display("FAIL reset_plot got %b want 0", vga_plot); end
    vectors++; if (vga_x !== 9'd0) begin miscompares++; $display("FAIL reset_x got %0d want 0", vga_x); end
    vectors++; if (vga_y !== 8'd0) begin miscompares++; $display("FAIL reset_y got %0d want 0", vga_y); end
    vectors++; if (vga_color !== 3'd0) begin miscompares++; $display("FAIL reset_color got %0d want 0", vga_color); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_tp got %b want 0", timeout_pulse); end
    vectors++; if (timeout_id !== 2'd0) begin miscompares++; $display("FAIL reset_tid got %0d want 0", timeout_id); end
    $display("test_reset: grant=%b busy=%b", grant, busy);
  endtask

  task automatic test_single_grant();
    reset = 1'b0; req = '0; plot_in = '0; step();
    req = 3'b100; plot_in = 3'b100;
    x_in[18 +: 9] = 9'd116; y_in[16 +: 8] = 8'd152; color_in[6 +: 3] = 3'd5;
    step();
    vectors++; if (grant !== 3'b100) begin miscompares++; $display("FAIL single_grant got %b want 100", grant); end
    step();
    vectors++; if (vga_x !== 9'd116) begin miscompares++; $display("FAIL single_x got %0d want 116", vga_x); end
    vectors++; if (vga_y !== 8'd152) begin miscompares++; $display("FAIL single_y got %0d want 152", vga_y); end
    vectors++; if (vga_color !== 3'd5) begin miscompares++; $display("FAIL single_color got %0d want 5", vga_color); end
    vectors++; if (vga_plot !== 1'b1) begin miscompares++; $display("FAIL single_plot got %b want 1", vga_plot); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b want 1", busy); end
    req = 3'b000;
    step();
    vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL single_release_grant got %b want 000", grant); end
    vectors++; if (vga_plot !== 1'b0) begin miscompares++; $display("FAIL single_release_plot got %b want 0", vga_plot); end
    $display("test_single_grant: x=%0d y=%0d c=%0d", vga_x, vga_y, vga_color);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    int o;
    reset = 1'b1; req = 3'b111; plot_in = '0; step();
    reset = 1'b0; step();
    for (int g = 0; g < 4; g++) begin
      o = g % N;
      want = '0; want[o] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (grant !== want) begin miscompares++; $display("FAIL rr_grant%0d_cyc%0d got %b want %b", g, c, grant, want); end
        if (c < 3) step();
      end
      req[o] = 1'b0; step();
      vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL rr_gap%0d got %b want 000", g, grant); end
      req[o] = 1'b1; step();
      $display("test_round_robin: burst %0d granted to %0d", g, o);
    end
    req = '0; step();
  endtask

  task automatic test_isolation();
    reset = 1'b0; req = '0; step();
    req = 3'b001; plot_in = 3'b100;
    x_in[0 +: 9] = 9'd17; x_in[18 +: 9] = 9'd300;
    step();
    vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL iso_grant got %b want 001", grant); end
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++; if (vga_plot !== 1'b0) begin miscompares++; $display("FAIL iso_plot%0d got %b want 0", c, vga_plot); end
      vectors++; if (vga_x !== 9'd17) begin miscompares++; $display("FAIL iso_x%0d got %0d want 17", c, vga_x); end
    end
    req = '0; plot_in = '0; step();
    $display("test_isolation: vga_x=%0d", vga_x);
  endtask

  task automatic test_watchdog();
    reset = 1'b1; step();
    reset = 1'b0; req = 3'b011; plot_in = 3'b001; step();
    for (int c = 0; c < MH; c++) begin
      vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL wd_hold%0d got %b want 001", c, grant); end
      step();
    end
    vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL wd_revoke got %b want 000", grant); end
    vectors++; if (timeout_pulse !== 1'b1) begin miscompares++; $display("FAIL wd_pulse got %b want 1", timeout_pulse); end
    vectors++; if (timeout_id !== 2'd0) begin miscompares++; $display("FAIL wd_id got %0d want 0", timeout_id); end
    vectors++; if (vga_plot !== 1'b0) begin miscompares++; $display("FAIL wd_plot got %b want 0", vga_plot); end
    step();
    vectors++; if (grant !== 3'b010) begin miscompares++; $display("FAIL wd_next got %b want 010", grant); end
    vectors++; if (timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL wd_pulse_len got %b want 0", timeout_pulse); end
    req[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL wd_locked%0d got %b want 000", c, grant); end
    end
    req[0] = 1'b0; step();
    req[0] = 1'b1; step();
    vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL wd_regrant got %b want 001", grant); end
    req = 3'b100; step();
    for (int c = 0; c < MH + 1; c++) step();
    vectors++; if (timeout_pulse !== 1'b1) begin miscompares++; $display("FAIL wd2_pulse got %b want 1", timeout_pulse); end
    vectors++; if (timeout_id !== 2'd2) begin miscompares++; $display("FAIL wd2_id got %0d want 2", timeout_id); end
    req = '0; step();
    $display("test_watchdog: last timeout_id=%0d", timeout_id);
  endtask

  task automatic test_reset_midburst();
    reset = 1'b1; step();
    reset = 1'b0; req = 3'b010; plot_in = 3'b010; step();
    vectors++; if (grant !== 3'b010) begin miscompares++; $display("FAIL mid_grant got %b want 010", grant); end
    step();
    vectors++; if (vga_plot !== 1'b1) begin miscompares++; $display("FAIL mid_plot got %b want 1", vga_plot); end
    reset = 1'b1; step();
    vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL mid_reset_grant got %b want 000", grant); end
    vectors++; if (vga_plot !== 1'b0) begin miscompares++; $display("FAIL mid_reset_plot got %b want 0", vga_plot); end
    reset = 1'b0; req = 3'b011; step();
    vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL mid_first got %b want 001", grant); end
    req = '0; step();
    $display("test_reset_midburst: grant=%b", grant);
  endtask

  task automatic test_random();
    int rem [N];
    int bursts = 0;
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 12);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          req[i] = ~req[i];
          rem[i] = $urandom_range(1, 12);
        end
        rem[i]--;
      end
      plot_in = 3'($urandom); x_in = 27'($urandom);
      y_in = 24'($urandom); color_in = 9'($urandom);
      step();
      if (e_tp) bursts++;
      vectors++; if (grant !== e_grant) begin miscompares++; $display("FAIL rnd_grant cyc%0d got %b want %b", cyc, grant, e_grant); end
      vectors++; if (vga_x !== e_x) begin miscompares++; $display("FAIL rnd_x cyc%0d got %0d want %0d", cyc, vga_x, e_x); end
      vectors++; if (vga_y !== e_y) begin miscompares++; $display("FAIL rnd_y cyc%0d got %0d want %0d", cyc, vga_y, e_y); end
      vectors++; if (vga_color !== e_c) begin miscompares++; $display("FAIL rnd_color cyc%0d got %0d want %0d", cyc, vga_color, e_c); end
      vectors++; if (vga_plot !== e_plot) begin miscompares++; $display("FAIL rnd_plot cyc%0d got %b want %b", cyc, vga_plot, e_plot); end
      vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL rnd_busy cyc%0d got %b want %b", cyc, busy, e_busy); end
      vectors++; if (timeout_pulse !== e_tp) begin miscompares++; $display("FAIL rnd_tp cyc%0d got %b want %b", cyc, timeout_pulse, e_tp); end
      vectors++; if (timeout_id !== e_tid) begin miscompares++; $display("FAIL rnd_tid cyc%0d got %0d want %0d", cyc, timeout_id, e_tid); end
    end
    reset = 1'b0;
    $display("test_random: 3000 cycles, %0d watchdog revocations", bursts);
  endtask

  initial begin
    reset = 1'b1; req = '0; plot_in = '0; x_in = '0; y_in = '0; color_in = '0;
    m_owner = -1; m_last = N - 1; m_used = 0; m_locked = '0;
    e_grant = '0; e_x = '0; e_y = '0; e_c = '0;
    e_plot = 1'b0; e_tp = 1'b0; e_tid = '0; e_busy = 1'b0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_isolation();
    test_watchdog();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
